conv_stream_engine: RTL and testbench
=====================================

# conv_stream_engine

Parametrised streaming 2-D convolution engine, the successor to the fixed 3×3/5×5 convolution unit.

- Accepts a per-job configuration, then a K×K signed filter and an N×N signed image over a valid/ready stream.
- Emits N×N outputs for stride 1, or ceil(N/2)² for stride 2, row-major over a backpressured output stream.
- Supports zero or replicate padding and ReLU, leaky ReLU or identity activation.
- Sits between the pixel DMA front-end and the feature-map writer.

## Interface
Parameters:
- DATA_W, 8, signed width of filter and image samples
- OUT_W, 16, signed output width
- MAX_IMG, 12, largest supported image side N
- KMAX, 5, largest filter side; legal K values are 3 and 5

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  high only in IDLE
- cfg_ksize  in  1  0 = 3×3, 1 = 5×5
- cfg_img_size  in  $clog2(MAX_IMG+1)  image side N
- cfg_pad_mode  in  1  0 = zero padding, 1 = replicate padding
- cfg_act_mode  in  2  0 = ReLU, 1 = leaky ReLU (÷10), 2 = identity, 3 = reserved, treated as identity
- cfg_stride2  in  1  1 = stride 2
- in_valid  in  1  sample offer
- in_ready  out  1  high in LOAD_FILT and LOAD_IMG
- in_data  in  DATA_W  signed sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  signed result
- out_last  out  1  high with the final result of a job
- cfg_err  out  1  one-cycle pulse on an illegal configuration

## Operation
- **States:** IDLE → LOAD_FILT → LOAD_IMG → CONV → DRAIN → IDLE.
- **IDLE:**
  - cfg_ready = 1.
  - The cfg handshake latches all cfg fields.
  - If N = 0 or N > MAX_IMG, pulse cfg_err and stay in IDLE.
- **LOAD_FILT:** accept K² coefficients, row-major, one per in_valid&in_ready beat.
- **LOAD_IMG:**
  - Accept N² pixels, row-major, into the image store.
  - The beat that accepts the last pixel moves the FSM to CONV.
- **CONV:**
  - One output position is issued into the pipeline per cycle while the pipeline is not stalled.
  - Issue order is row-major; stride 2 visits even rows and columns only.
  - After the last position is issued, go to DRAIN.
- **DRAIN:** wait until the last result is accepted, then go to IDLE.
- **Window fetch:**
  - Tap (r+dr, c+dc), with dr and dc in −K/2..K/2.
  - Zero pad: an out-of-range tap reads 0.
  - Replicate pad: the tap coordinate is clamped to 0..N−1.
  - Padding is computed by index and is never stored.
- **Accumulator:**
  - Products are 2·DATA_W bits, signed.
  - The sum is 2·DATA_W + $clog2(KMAX²) bits, computed exactly.
- **Activation:**
  - ReLU: negative → 0.
  - Leaky: negative → sum/10, truncated toward zero.
  - Identity: passthrough.
  - The result is then saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **Illegal inputs:**
  - cfg_valid outside IDLE is not accepted.
  - in_valid outside the LOAD states is ignored.

## Timing
- **Reset values:**
  - out_valid = 0, out_data = 0, out_last = 0, cfg_err = 0.
  - in_ready = 0, cfg_ready = 1, state = IDLE.
  - Filter and image stores are not reset.
- **Latency:** 2-stage pipeline.
  - S0 registers the window products.
  - S1 registers the activated, saturated sum into the output.
  - The first out_valid is asserted 2 cycles after the last pixel beat is accepted.
- **Throughput:** 1 result per cycle while out_ready = 1.
- **Backpressure:**
  - out_valid && !out_ready freezes S0, S1 and the issue counter.
  - out_data and out_last hold stable; no result is dropped or duplicated.
- **Output stability:** out_valid never deasserts without a handshake.
- **Job boundary:** cfg_ready returns the cycle after the out_last handshake.
- **Reset mid-job:** rst asserted in any state forces the reset values immediately (asynchronously); the partial job is discarded.

## Structure
- Package conv_stream_pkg holds:
  - the state enum;
  - the act_mode_e enum;
  - the accumulator width function;
  - the saturate and leaky-divide functions.
- One sub-module, conv_mac_tree: a KMAX² multiplier array plus adder tree. A 3×3 job masks the outer ring with zeros.

## Test plan
- **Zero pad:** 3×3 all-ones filter, 3×3 all-ones image, zero pad, ReLU, stride 1 → 4,6,4,6,9,6,4,6,4, with out_last on the ninth result.
- **Replicate pad:** same stimulus with replicate pad → nine results of 9.
- **Leaky ReLU:** 3×3 filter with centre −25 and all other taps 0, 4×4 all-ones image → sixteen results of −2; identity mode → −25.
- **Saturation and stride 2:** 5×5 filter all 127, 5×5 image all 127, replicate pad, stride 2 → nine results of 32767 (exact sum 403225).
- **Backpressure:** hold out_ready low 5 cycles at result 3 → out_data stable throughout, all N² results delivered in order exactly once.
- **Errors and reset:**
  - cfg N = 0 → cfg_err pulse, cfg_ready stays 1.
  - rst during CONV → out_valid = 0 immediately.
  - A new job after reset produces correct results.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution engine.
package conv_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_FILT,
    ST_LOAD_IMG,
    ST_CONV,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_IDENT = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_e;

  // Exact accumulator width: product width plus growth for KMAX^2 terms.
  function automatic int acc_width(input int data_w, input int kmax);
    return 2 * data_w + $clog2(kmax * kmax);
  endfunction

  // Leaky slope of 1/10; signed division truncates toward zero.
  function automatic longint leaky_div(input longint v);
    return v / 64'sd10;
  endfunction

  // Clamp to the signed range of an out_w-bit result.
  function automatic longint saturate(input longint v, input int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// KMAX x KMAX multiplier array with registered products (S0) and an
// exact-width adder tree. A 3x3 job forces the outer ring products to zero.
module conv_mac_tree
  import conv_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KMAX   = 5,
  parameter int ACC_W  = acc_width(DATA_W, KMAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ksize5,
  input  logic signed [DATA_W-1:0] taps  [KMAX*KMAX],
  input  logic signed [DATA_W-1:0] coefs [KMAX*KMAX],
  output logic signed [ACC_W-1:0]  sum
);

  localparam int NT = KMAX * KMAX;
  localparam int KH = KMAX / 2;
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] prod_q [NT];

  for (genvar t = 0; t < NT; t++) begin : g_tap
    localparam int  DR      = t / KMAX - KH;
    localparam int  DC      = t % KMAX - KH;
    localparam bit  IN_CORE = (DR >= -1) && (DR <= 1) && (DC >= -1) && (DC <= 1);

    logic signed [PW-1:0] prod_d;
    assign prod_d = taps[t] * coefs[t];

    // S0: capture this tap's product, zeroed outside the 3x3 core for K=3
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     prod_q[t] <= '0;
      else if (en) prod_q[t] <= (ksize5 || IN_CORE) ? prod_d : '0;
    end
  end

  // Sign-extended sum of all registered products
  always_comb begin
    // NOTE: combinational outputs get a default before the loop so no latch is inferred.
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + ACC_W'(prod_q[i]);
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming K x K (3 or 5) signed convolution over an N x N image with
// zero/replicate padding, stride 1/2 and ReLU / leaky / identity activation.
module conv_stream_engine
  import conv_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int MAX_IMG = 12,
  parameter int KMAX    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           cfg_ksize,
  input  logic [$clog2(MAX_IMG+1)-1:0]   cfg_img_size,
  input  logic                           cfg_pad_mode,
  input  logic [1:0]                     cfg_act_mode,
  input  logic                           cfg_stride2,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_last,
  output logic                           cfg_err
);

  localparam int NW    = $clog2(MAX_IMG + 1);
  localparam int NT    = KMAX * KMAX;
  localparam int KH    = KMAX / 2;
  localparam int CW    = $clog2(KMAX);
  localparam int FA_W  = $clog2(NT);
  localparam int IA_W  = $clog2(MAX_IMG * MAX_IMG);
  localparam int ACC_W = acc_width(DATA_W, KMAX);

  state_e state_q, state_d;

  logic            ksize5_q, pad_rep_q, s2_q;
  logic [NW-1:0]   n_q;
  act_mode_e       act_q;

  logic [CW-1:0]   fr, fc;
  logic [NW-1:0]   pr, pc, ir, ic;

  logic signed [DATA_W-1:0] filt_mem [NT];
  logic signed [DATA_W-1:0] img_mem  [MAX_IMG*MAX_IMG];
  logic signed [DATA_W-1:0] taps     [NT];

  logic cfg_fire, cfg_bad, in_fire, stall, issue, issue_last;
  logic filt_done, img_done, col_wrap, row_wrap, filt_wrap, img_wrap;
  logic [CW-1:0]   k_last;
  logic [NW-1:0]   step;
  logic [NW:0]     ic_nx, ir_nx;
  logic [FA_W-1:0] f_addr;
  logic [IA_W-1:0] i_addr;

  logic                     s0_valid, s0_last;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [OUT_W-1:0]  act_result;
  longint                   sum_l, act_l, sat_l;

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD_FILT) || (state_q == ST_LOAD_IMG);

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_img_size == '0) || (cfg_img_size > NW'(MAX_IMG));
  assign in_fire   = in_valid && in_ready;
  assign stall     = out_valid && !out_ready;

  assign k_last    = ksize5_q ? CW'(4) : CW'(2);
  assign filt_wrap = (fc == k_last);
  assign img_wrap  = (pc == n_q - NW'(1));
  assign filt_done = in_fire && (state_q == ST_LOAD_FILT) && filt_wrap && (fr == k_last);
  assign img_done  = in_fire && (state_q == ST_LOAD_IMG) && img_wrap && (pr == n_q - NW'(1));

  assign step       = s2_q ? NW'(2) : NW'(1);
  assign ic_nx      = {1'b0, ic} + {1'b0, step};
  assign ir_nx      = {1'b0, ir} + {1'b0, step};
  assign col_wrap   = (ic_nx >= {1'b0, n_q});
  assign row_wrap   = (ir_nx >= {1'b0, n_q});
  assign issue      = (state_q == ST_CONV) && !stall;
  assign issue_last = col_wrap && row_wrap;

  // A 3x3 filter lands in the centre of the KMAX x KMAX coefficient grid
  assign f_addr = FA_W'((int'(fr) + (ksize5_q ? 0 : (KMAX - 3) / 2)) * KMAX
                        + int'(fc) + (ksize5_q ? 0 : (KMAX - 3) / 2));
  assign i_addr = IA_W'(int'(pr) * MAX_IMG + int'(pc));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (cfg_fire && !cfg_bad) state_d = ST_LOAD_FILT;
      ST_LOAD_FILT: if (filt_done)            state_d = ST_LOAD_IMG;
      ST_LOAD_IMG:  if (img_done)             state_d = ST_CONV;
      ST_CONV:      if (issue && issue_last)  state_d = ST_DRAIN;
      ST_DRAIN:     if (out_valid && out_ready && out_last) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Latch the job configuration on the cfg handshake; flag illegal sizes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ksize5_q  <= 1'b0;
      n_q       <= '0;
      pad_rep_q <= 1'b0;
      act_q     <= ACT_RELU;
      s2_q      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && cfg_bad;
      if (cfg_fire) begin
        ksize5_q  <= cfg_ksize;
        n_q       <= cfg_img_size;
        pad_rep_q <= cfg_pad_mode;
        act_q     <= act_mode_e'(cfg_act_mode);
        s2_q      <= cfg_stride2;
      end
    end
  end

  // Load-position and issue-position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr <= '0; fc <= '0; pr <= '0; pc <= '0; ir <= '0; ic <= '0;
    end else if (cfg_fire) begin
      fr <= '0; fc <= '0; pr <= '0; pc <= '0; ir <= '0; ic <= '0;
    end else begin
      if (in_fire && state_q == ST_LOAD_FILT) begin
        fc <= filt_wrap ? '0 : fc + CW'(1);
        if (filt_wrap) fr <= fr + CW'(1);
      end
      if (in_fire && state_q == ST_LOAD_IMG) begin
        pc <= img_wrap ? '0 : pc + NW'(1);
        if (img_wrap) pr <= pr + NW'(1);
      end
      if (issue) begin
        ic <= col_wrap ? '0 : ic_nx[NW-1:0];
        if (col_wrap) ir <= ir_nx[NW-1:0];
      end
    end
  end

  // Filter and image stores
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; every entry read by a job is written by that job first.
    if (in_fire && state_q == ST_LOAD_FILT) filt_mem[f_addr] <= in_data;
    if (in_fire && state_q == ST_LOAD_IMG)  img_mem[i_addr]  <= in_data;
  end

  for (genvar t = 0; t < NT; t++) begin : g_win
    localparam int DR = t / KMAX - KH;
    localparam int DC = t % KMAX - KH;
    int   tr, tc, trc, tcc;
    logic oob;

    // Fetch one window tap; padding is resolved from the index, never stored
    always_comb begin
      tr  = int'(ir) + DR;
      tc  = int'(ic) + DC;
      trc = (tr < 0) ? 0 : ((tr >= int'(n_q)) ? int'(n_q) - 1 : tr);
      tcc = (tc < 0) ? 0 : ((tc >= int'(n_q)) ? int'(n_q) - 1 : tc);
      oob = (tr != trc) || (tc != tcc);
      taps[t] = (oob && !pad_rep_q) ? '0 : img_mem[IA_W'(trc * MAX_IMG + tcc)];
    end
  end

  conv_mac_tree #(
    .DATA_W (DATA_W),
    .KMAX   (KMAX),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (issue),
    .ksize5 (ksize5_q),
    .taps   (taps),
    .coefs  (filt_mem),
    .sum    (mac_sum)
  );

  // Activation followed by output saturation
  always_comb begin
    sum_l = longint'(mac_sum);
    act_l = sum_l;
    if (sum_l < 0) begin
      case (act_q)
        ACT_RELU:  act_l = 0;
        ACT_LEAKY: act_l = leaky_div(sum_l);
        default:   act_l = sum_l;
      endcase
    end
    sat_l      = saturate(act_l, OUT_W);
    act_result = sat_l[OUT_W-1:0];
  end

  // S0 valid/last tags travel alongside the registered products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
    end else if (!stall) begin
      s0_valid <= issue;
      s0_last  <= issue && issue_last;
    end
  end

  // S1 output register, frozen while the consumer applies backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= s0_valid;
      out_last  <= s0_valid && s0_last;
      if (s0_valid) out_data <= act_result;
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine: table-driven jobs plus
// backpressure, error and reset sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_conv_stream_engine;

  localparam int DATA_W  = 8;
  localparam int OUT_W   = 16;
  localparam int MAX_IMG = 12;
  localparam int KMAX    = 5;
  localparam int NW      = $clog2(MAX_IMG + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_valid, cfg_ready, cfg_ksize, cfg_pad_mode, cfg_stride2;
  logic [NW-1:0]            cfg_img_size;
  logic [1:0]               cfg_act_mode;
  logic                     in_valid, in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid, out_ready, out_last, cfg_err;
  logic signed [OUT_W-1:0]  out_data;

  always #5 clk = ~clk;

  conv_stream_engine #(
    .DATA_W (DATA_W), .OUT_W (OUT_W), .MAX_IMG (MAX_IMG), .KMAX (KMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ksize    (cfg_ksize),
    .cfg_img_size (cfg_img_size),
    .cfg_pad_mode (cfg_pad_mode),
    .cfg_act_mode (cfg_act_mode),
    .cfg_stride2  (cfg_stride2),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .cfg_err      (cfg_err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int               k, n, pad, act, s2;
    int               filt_kind;   // 0: every tap = fval, 1: centre = fval, rest 0
    int               fval, pval;
    logic [24:0][15:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rx_total = 0;

  int cur_k, cur_n, cur_pad, cur_act, cur_s2;
  int filt_m [KMAX][KMAX];
  int img_m  [MAX_IMG][MAX_IMG];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard monitor: every accepted result is popped and compared in order
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected none", out_data);
      end else begin
        e = sb.pop_front();
        check($sformatf("out_data[%0d]", rx_total), longint'(out_data), longint'($signed(e.data)));
        check($sformatf("out_last[%0d]", rx_total), longint'(out_last), longint'(e.last));
      end
      rx_total++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference convolution of the current job at output position (r, c)
  function automatic int ref_out(input int r, input int c);
    int kh, s, tr, tc, px;
    kh = cur_k / 2;
    s  = 0;
    for (int dr = -kh; dr <= kh; dr++) begin
      for (int dc = -kh; dc <= kh; dc++) begin
        tr = r + dr;
        tc = c + dc;
        if (tr < 0 || tr >= cur_n || tc < 0 || tc >= cur_n) begin
          if (cur_pad != 0) begin
            tr = (tr < 0) ? 0 : (tr >= cur_n ? cur_n - 1 : tr);
            tc = (tc < 0) ? 0 : (tc >= cur_n ? cur_n - 1 : tc);
            px = img_m[tr][tc];
          end else begin
            px = 0;
          end
        end else begin
          px = img_m[tr][tc];
        end
        s += filt_m[dr + kh][dc + kh] * px;
      end
    end
    if (s < 0 && cur_act == 0) s = 0;
    if (s < 0 && cur_act == 1) s = s / 10;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int n_outputs();
    int side;
    side = (cur_s2 != 0) ? (cur_n + 1) / 2 : cur_n;
    return side * side;
  endfunction

  task automatic push_model();
    int   step;
    exp_t e;
    step = (cur_s2 != 0) ? 2 : 1;
    for (int r = 0; r < cur_n; r += step) begin
      for (int c = 0; c < cur_n; c += step) begin
        e.data = 16'(ref_out(r, c));
        e.last = (r + step >= cur_n) && (c + step >= cur_n);
        sb.push_back(e);
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < KMAX; r++)
      for (int c = 0; c < KMAX; c++)
        filt_m[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < MAX_IMG; r++)
      for (int c = 0; c < MAX_IMG; c++)
        img_m[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Present one input beat; caller is positioned just after a rising edge
  task automatic send_beat(input int d);
    int budget;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    budget   = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (!in_ready && budget > 0);
    if (!in_ready) fail_now("in_ready_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job();
    int budget;
    cfg_ksize    = (cur_k == 5);
    cfg_img_size = NW'(cur_n);
    cfg_pad_mode = cur_pad[0];
    cfg_act_mode = cur_act[1:0];
    cfg_stride2  = cur_s2[0];
    cfg_valid    = 1'b1;
    budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (!cfg_ready && budget > 0);
    if (!cfg_ready) fail_now("cfg_ready_wait");
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < cur_k * cur_k; i++) send_beat(filt_m[i / cur_k][i % cur_k]);
    for (int i = 0; i < cur_n * cur_n; i++) send_beat(img_m[i / cur_n][i % cur_n]);
    in_valid = 1'b0;
  endtask

  // Called right after the last pixel beat: first result appears two cycles later
  task automatic check_latency();
    @(negedge clk);
    @(negedge clk);
    check("latency_before", longint'(out_valid), 0);
    @(negedge clk);
    check("latency_first", longint'(out_valid), 1);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 2000;
    while ((sb.size() != 0 || !cfg_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int k, input int n, input int pad, input int act,
                         input int s2, input int fk, input int fv, input int pv, input int ev);
    vecs[i].k = k;  vecs[i].n = n;  vecs[i].pad = pad; vecs[i].act = act; vecs[i].s2 = s2;
    vecs[i].filt_kind = fk; vecs[i].fval = fv; vecs[i].pval = pv;
    for (int j = 0; j < 25; j++) vecs[i].exp[j] = 16'(ev);
  endtask

  initial begin
    int   base;
    int   held;
    int   budget;
    exp_t e;
    int   zp [9];

    // k  n  pad act s2 fk  fval  pval  expected
    set_vec(0, 3, 3, 0, 0, 0, 0,    1,   1,      0);
    set_vec(1, 3, 3, 1, 0, 0, 0,    1,   1,      9);
    set_vec(2, 3, 4, 0, 1, 0, 1,  -25,   1,     -2);
    set_vec(3, 3, 4, 0, 2, 0, 1,  -25,   1,    -25);
    set_vec(4, 5, 5, 1, 0, 1, 0,  127, 127,  32767);
    set_vec(5, 3, 4, 0, 0, 0, 1,  -25,   1,      0);
    set_vec(6, 3, 4, 1, 3, 0, 1,  -25,   1,    -25);
    set_vec(7, 5, 5, 1, 2, 0, 0, -128, 127, -32768);
    zp = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
    for (int j = 0; j < 9; j++) vecs[0].exp[j] = 16'(zp[j]);

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ksize = 1'b0; cfg_img_size = '0; cfg_pad_mode = 1'b0;
    cfg_act_mode = 2'd0; cfg_stride2 = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    #12;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data",  longint'(out_data),  0);
    check("rst_out_last",  longint'(out_last),  0);
    check("rst_cfg_err",   longint'(cfg_err),   0);
    check("rst_in_ready",  longint'(in_ready),  0);
    check("rst_cfg_ready", longint'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven jobs with hand-derived expected results
    for (int v = 0; v < 8; v++) begin
      cur_k = vecs[v].k; cur_n = vecs[v].n; cur_pad = vecs[v].pad;
      cur_act = vecs[v].act; cur_s2 = vecs[v].s2;
      for (int r = 0; r < KMAX; r++)
        for (int c = 0; c < KMAX; c++)
          filt_m[r][c] = (vecs[v].filt_kind == 0 || (r == cur_k / 2 && c == cur_k / 2))
                         ? vecs[v].fval : 0;
      for (int r = 0; r < MAX_IMG; r++)
        for (int c = 0; c < MAX_IMG; c++)
          img_m[r][c] = vecs[v].pval;
      for (int j = 0; j < n_outputs(); j++) begin
        e.data = vecs[v].exp[j];
        e.last = (j == n_outputs() - 1);
        sb.push_back(e);
      end
      base = rx_total;
      drive_job();
      check_latency();
      wait_drain($sformatf("drain_vec%0d", v));
      check($sformatf("count_vec%0d", v), longint'(rx_total - base), longint'(n_outputs()));
    end

    // Illegal sizes: one-cycle cfg_err, FSM stays idle
    for (int t = 0; t < 2; t++) begin
      cfg_img_size = (t == 0) ? NW'(0) : NW'(MAX_IMG + 1);
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("err_pulse",     longint'(cfg_err),   1);
      check("err_cfg_ready", longint'(cfg_ready), 1);
      check("err_in_ready",  longint'(in_ready),  0);
      @(negedge clk);
      check("err_clear",     longint'(cfg_err),   0);
      @(posedge clk);
      #1;
    end

    // Backpressure: stall five cycles while result 3 is presented
    cur_k = 3; cur_n = 6; cur_pad = 1; cur_act = 1; cur_s2 = 0;
    fill_random();
    push_model();
    base = rx_total;
    fork
      begin
        drive_job();
        wait_drain("drain_bp");
      end
      begin
        budget = 1000;
        do begin
          @(posedge clk);
          #1;
          budget--;
        end while (rx_total < base + 3 && budget > 0);
        if (rx_total < base + 3) fail_now("bp_wait");
        out_ready = 1'b0;
        held = int'(out_data);
        check("bp_valid_held", longint'(out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_data_stable", longint'(out_data),  longint'(held));
          check("bp_valid_stable", longint'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_count", longint'(rx_total - base), 36);

    // Reset in the middle of a job's output phase
    cur_k = 5; cur_n = 12; cur_pad = 0; cur_act = 2; cur_s2 = 0;
    fill_random();
    push_model();
    base = rx_total;
    drive_job();
    budget = 200;
    while (rx_total < base + 5 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (rx_total < base + 5) fail_now("rst_job_wait");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_last",  longint'(out_last),  0);
    check("midrst_out_data",  longint'(out_data),  0);
    check("midrst_cfg_ready", longint'(cfg_ready), 1);
    check("midrst_in_ready",  longint'(in_ready),  0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh jobs after reset
    cur_k = 5; cur_n = 7; cur_pad = 0; cur_act = 2; cur_s2 = 1;
    fill_random();
    push_model();
    base = rx_total;
    drive_job();
    check_latency();
    wait_drain("drain_post_rst");
    check("count_post_rst", longint'(rx_total - base), 16);

    cur_k = 3; cur_n = 5; cur_pad = 1; cur_act = 0; cur_s2 = 1;
    fill_random();
    push_model();
    base = rx_total;
    drive_job();
    wait_drain("drain_final");
    check("count_final", longint'(rx_total - base), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
